// File: rtl/axi_ad9371_rx_pkg.sv
// Shared types and sizing for the AD9371 receive-path sample packer.
package axi_ad9371_rx_pkg;

  localparam int unsigned LANE_W = 16;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned ACC_W  = 128;
  localparam int unsigned WORD_W = LANE_W * NUM_CH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RUN
  } state_e;

endpackage

// File: rtl/axi_ad9371_rx_pack_compact.sv
// Squeezes the enabled 16-bit channel samples together, lowest channel in the lowest bits.
module axi_ad9371_rx_pack_compact
  import axi_ad9371_rx_pkg::*;
(
  input  logic [WORD_W-1:0] data_i,
  input  logic [NUM_CH-1:0] enable_i,
  output logic [2:0]        count_o,
  output logic [WORD_W-1:0] packed_o
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    packed_o = '0;
    count_o  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (enable_i[i]) begin
        packed_o[count_o*LANE_W +: LANE_W] = data_i[i*LANE_W +: LANE_W];
        count_o = count_o + 3'd1;
      end
    end
  end

endmodule

// File: rtl/axi_ad9371_rx_pack.sv
// AD9371 RX channel packer: compacts enabled lanes into 64-bit words.
// Optional test ramp source enabled by defining AXI_AD9371_RX_PACK_RAMP_EN.
module axi_ad9371_rx_pack
  import axi_ad9371_rx_pkg::*;
#(
  parameter int unsigned SYNC_ENABLE = 1
) (
  input  logic              adc_clk,
  input  logic              adc_rstn,
  input  logic              adc_valid,
  input  logic [WORD_W-1:0] adc_data,
  input  logic [NUM_CH-1:0] adc_enable,
  input  logic              adc_sync_arm,
  input  logic              adc_sync,
  input  logic              adc_dovf,
  input  logic              adc_ovf_clr,
  input  logic              adc_ramp_en,
  output logic              pack_valid,
  output logic [WORD_W-1:0] pack_data,
  output logic              pack_sync,
  output logic              adc_ovf_sticky
);

  state_e              state_q, state_d;
  logic [2:0]          fill_q, fill_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                pack_valid_q, pack_valid_d;
  logic                pack_sync_q, pack_sync_d;
  logic [WORD_W-1:0]   pack_data_q, pack_data_d;
  logic                first_q, first_d;
  logic                ovf_q, ovf_d;
  logic [NUM_CH-1:0]   enable_q;

  logic [WORD_W-1:0]   sample_data;
  logic [2:0]          lane_cnt;
  logic [WORD_W-1:0]   lane_vec;
  logic [2:0]          fill_sum;
  logic [ACC_W-1:0]    merged;
  logic                abort, capture, first_cur;

`ifdef AXI_AD9371_RX_PACK_RAMP_EN
  logic [LANE_W-1:0] ramp_q, ramp_d, ramp_cur;

  // The ramp restarts at zero for the first sample of every capture.
  always_comb begin
    ramp_cur    = (state_q == ST_RUN) ? ramp_q : '0;
    ramp_d      = capture ? ramp_cur + 1'b1 : ramp_cur;
    sample_data = adc_ramp_en ? {NUM_CH{ramp_cur}} : adc_data;
  end

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) ramp_q <= '0;
    else           ramp_q <= ramp_d;
  end
`else
  logic unused_ramp_en;
  assign unused_ramp_en = adc_ramp_en;
  assign sample_data    = adc_data;
`endif

  axi_ad9371_rx_pack_compact u_compact (
    .data_i   (sample_data),
    .enable_i (adc_enable),
    .count_o  (lane_cnt),
    .packed_o (lane_vec)
  );

  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    acc_d        = acc_q;
    pack_valid_d = 1'b0;
    pack_sync_d  = 1'b0;
    pack_data_d  = pack_data_q;
    first_d      = first_q;
    capture      = 1'b0;

    abort     = (adc_enable != enable_q) || (adc_enable == '0);
    fill_sum  = fill_q + lane_cnt;
    merged    = acc_q | ({{(ACC_W-WORD_W){1'b0}}, lane_vec} << (fill_q * LANE_W));
    first_cur = (state_q == ST_RUN) ? first_q : 1'b1;

    if (abort) begin
      state_d = ST_IDLE;
      fill_d  = '0;
      acc_d   = '0;
      first_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (SYNC_ENABLE == 0)  state_d = ST_RUN;
          else if (adc_sync_arm) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (adc_valid && adc_sync) begin
            state_d = ST_RUN;
            capture = 1'b1;
          end
        end
        ST_RUN:  capture = adc_valid;
        default: state_d = ST_IDLE;
      endcase

      // fill never exceeds 3 between cycles, so fill_sum tops out at 7.
      if (capture) begin
        if (fill_sum[2]) begin
          pack_valid_d = 1'b1;
          pack_sync_d  = first_cur;
          pack_data_d  = merged[WORD_W-1:0];
          acc_d        = merged >> WORD_W;
          fill_d       = {1'b0, fill_sum[1:0]};
          first_d      = 1'b0;
        end else begin
          acc_d   = merged;
          fill_d  = fill_sum;
          first_d = first_cur;
        end
      end
    end

    ovf_d = (pack_valid_q && adc_dovf) ? 1'b1 : (adc_ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!adc_rstn) begin
      state_q      <= ST_IDLE;
      fill_q       <= '0;
      acc_q        <= '0;
      pack_valid_q <= 1'b0;
      pack_sync_q  <= 1'b0;
      pack_data_q  <= '0;
      first_q      <= 1'b1;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      acc_q        <= acc_d;
      pack_valid_q <= pack_valid_d;
      pack_sync_q  <= pack_sync_d;
      pack_data_q  <= pack_data_d;
      first_q      <= first_d;
      ovf_q        <= ovf_d;
    end
  end

  // NOTE: deliberately unreset so it keeps tracking adc_enable while reset is held.
  always_ff @(posedge adc_clk) begin
    enable_q <= adc_enable;
  end

  assign pack_valid     = pack_valid_q;
  assign pack_sync      = pack_sync_q;
  assign pack_data      = pack_data_q;
  assign adc_ovf_sticky = ovf_q;

endmodule

// File: tb/tb_axi_ad9371_rx_pack.sv
// Bench for axi_ad9371_rx_pack: SYNC_ENABLE=0 and =1 instances against a sample-queue model.
module tb_axi_ad9371_rx_pack;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid, arm, sync, dovf, clr, ramp_en;
  logic [63:0] data;
  logic [3:0]  en;

  logic        pv  [2];
  logic        ps  [2];
  logic        ovf [2];
  logic [63:0] pd  [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_ad9371_rx_pack #(.SYNC_ENABLE(0)) u_dut0 (
    .adc_clk(clk), .adc_rstn(rstn), .adc_valid(valid), .adc_data(data),
    .adc_enable(en), .adc_sync_arm(arm), .adc_sync(sync), .adc_dovf(dovf),
    .adc_ovf_clr(clr), .adc_ramp_en(ramp_en), .pack_valid(pv[0]),
    .pack_data(pd[0]), .pack_sync(ps[0]), .adc_ovf_sticky(ovf[0])
  );

  axi_ad9371_rx_pack #(.SYNC_ENABLE(1)) u_dut1 (
    .adc_clk(clk), .adc_rstn(rstn), .adc_valid(valid), .adc_data(data),
    .adc_enable(en), .adc_sync_arm(arm), .adc_sync(sync), .adc_dovf(dovf),
    .adc_ovf_clr(clr), .adc_ramp_en(ramp_en), .pack_valid(pv[1]),
    .pack_data(pd[1]), .pack_sync(ps[1]), .adc_ovf_sticky(ovf[1])
  );

  // Reference model: a plain FIFO of 16-bit samples per instance; four queued samples make a word.
  logic [15:0] mbuf [2][8];
  int          mcnt [2];
  bit          mrun [2], marm [2], mfirst [2];
  logic [3:0]  men_prev;
  logic        exp_v [2], exp_s [2], exp_ovf [2];
  logic [63:0] exp_d [2];

  logic [63:0] got0[$], got1[$];
  logic        gs0[$], gs1[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit abort, take;
    if (!rstn) begin
      for (int d = 0; d < 2; d++) begin
        mcnt[d] = 0; mrun[d] = 0; marm[d] = 0; mfirst[d] = 1;
        exp_v[d] = 0; exp_s[d] = 0; exp_ovf[d] = 0; exp_d[d] = '0;
      end
      men_prev = en;
      return;
    end
    abort = (en != men_prev) || (en == 4'h0);
    for (int d = 0; d < 2; d++) begin
      if (exp_v[d] && dovf) exp_ovf[d] = 1'b1;
      else if (clr)         exp_ovf[d] = 1'b0;
      exp_v[d] = 1'b0;
      exp_s[d] = 1'b0;
      take = 0;
      if (abort) begin
        mrun[d] = 0; marm[d] = 0; mcnt[d] = 0;
      end else if (mrun[d]) begin
        take = valid;
      end else if (marm[d]) begin
        if (valid && sync) begin
          marm[d] = 0; mrun[d] = 1; mfirst[d] = 1; take = 1;
        end
      end else if (d == 0) begin
        mrun[d] = 1; mfirst[d] = 1;
      end else if (arm) begin
        marm[d] = 1;
      end
      if (take)
        for (int ch = 0; ch < 4; ch++)
          if (en[ch]) begin
            mbuf[d][mcnt[d]] = data[ch*16 +: 16];
            mcnt[d]++;
          end
      if (mcnt[d] >= 4) begin
        exp_v[d]  = 1'b1;
        exp_s[d]  = mfirst[d];
        mfirst[d] = 0;
        exp_d[d]  = {mbuf[d][3], mbuf[d][2], mbuf[d][1], mbuf[d][0]};
        for (int i = 0; i < mcnt[d] - 4; i++) mbuf[d][i] = mbuf[d][i+4];
        mcnt[d] -= 4;
      end
    end
    men_prev = en;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("valid%0d", d), pv[d], exp_v[d]);
      check($sformatf("sync%0d", d), ps[d], exp_s[d]);
      check($sformatf("ovf%0d", d), ovf[d], exp_ovf[d]);
      if (exp_v[d]) check($sformatf("data%0d", d), pd[d], exp_d[d]);
    end
    if (pv[0]) begin got0.push_back(pd[0]); gs0.push_back(ps[0]); end
    if (pv[1]) begin got1.push_back(pd[1]); gs1.push_back(ps[1]); end
  endtask

  task automatic drive(input bit v, input logic [63:0] d, input bit a, input bit s);
    valid = v; data = d; arm = a; sync = s;
    tick();
  endtask

  task automatic set_enable(input logic [3:0] e, input int settle);
    en = 4'h0;
    drive(0, '0, 0, 0);
    en = e;
    repeat (settle) drive(0, '0, 0, 0);
  endtask

  task automatic clear_logs();
    got0.delete(); got1.delete(); gs0.delete(); gs1.delete();
  endtask

  initial begin
    rstn = 0; valid = 0; arm = 0; sync = 0; dovf = 0; clr = 0; ramp_en = 0;
    data = '0; en = 4'h0;
    repeat (3) tick();
    check("rst_data0", pd[0], 64'h0);
    check("rst_valid1", pv[1], 1'b0);
    rstn = 1;

    // Four lanes, no sync: every valid is one word equal to the input.
    set_enable(4'hF, 2);
    clear_logs();
    repeat (4) drive(1, 64'h0004_0003_0002_0001, 0, 0);
    check("s1_count", got0.size(), 4);
    check("s1_word0", got0[0], 64'h0004_0003_0002_0001);
    check("s1_word3", got0[3], 64'h0004_0003_0002_0001);
    check("s1_sync0", gs0[0], 1'b1);
    check("s1_sync1", gs0[1], 1'b0);

    // Single lane: eight samples make two words.
    set_enable(4'h1, 2);
    clear_logs();
    for (int k = 1; k <= 8; k++) drive(1, 64'(k), 0, 0);
    drive(0, '0, 0, 0);
    check("s2_count", got0.size(), 2);
    check("s2_word0", got0[0], 64'h0004_0003_0002_0001);
    check("s2_word1", got0[1], 64'h0008_0007_0006_0005);

    // Three lanes: four valids make three words.
    set_enable(4'h7, 2);
    clear_logs();
    for (int k = 0; k < 4; k++)
      drive(1, {16'h0, 16'(3*k+3), 16'(3*k+2), 16'(3*k+1)}, 0, 0);
    drive(0, '0, 0, 0);
    check("s3_count", got0.size(), 3);
    check("s3_word0", got0[0], 64'h0004_0003_0002_0001);
    check("s3_word1", got0[1], 64'h0008_0007_0006_0005);
    check("s3_word2", got0[2], 64'h000C_000B_000A_0009);

    // Armed instance waits for sync; the sync sample starts the first word.
    set_enable(4'hF, 2);
    drive(0, '0, 1, 0);
    clear_logs();
    for (int k = 1; k <= 10; k++)
      drive(1, {16'(4*k+3), 16'(4*k+2), 16'(4*k+1), 16'(4*k)}, 0, 0);
    check("s4_no_out", got1.size(), 0);
    drive(1, {16'd47, 16'd46, 16'd45, 16'd44}, 0, 1);
    check("s4_count", got1.size(), 1);
    check("s4_word0", got1[0], {16'd47, 16'd46, 16'd45, 16'd44});
    check("s4_sync0", gs1[0], 1'b1);

    // Enable change mid-word discards the residue.
    set_enable(4'h1, 2);
    clear_logs();
    drive(1, 64'h11, 0, 0);
    drive(1, 64'h22, 0, 0);
    en = 4'h3;
    repeat (6) drive(0, '0, 0, 0);
    check("s5_discard", got0.size(), 0);

    // Overflow while a word is out, with clear in the same cycle: set wins.
    set_enable(4'hF, 2);
    drive(1, 64'h0123_4567_89AB_CDEF, 0, 0);
    dovf = 1; clr = 1;
    drive(0, '0, 0, 0);
    check("s5_ovf_set", ovf[0], 1'b1);
    dovf = 0;
    drive(0, '0, 0, 0);
    check("s5_ovf_clr", ovf[0], 1'b0);
    clr = 0;

    // Randomised traffic, with one mid-stream reset.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(63) == 0) en = 4'($urandom_range(15));
      dovf = ($urandom_range(3) == 0);
      clr  = ($urandom_range(15) == 0);
      rstn = !(c >= 1500 && c < 1502);
      drive($urandom_range(1), {$urandom, $urandom},
            $urandom_range(15) == 0, $urandom_range(7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_ad9371_rx_pack.md
AXI_AD9371_RX_PACK -- requirements
Module: axi_ad9371_rx_pack

Interface
REQ-001 SHALL have parameter SYNC_ENABLE, default 1; 1 = capture waits for arm plus sync, 0 = capture starts as soon as any channel is enabled.
REQ-002 SHALL have ports:
- adc_clk  in  1  single clock.
- adc_rstn  in  1  asynchronous, active-low reset.
- adc_valid  in  1  qualifies adc_data.
- adc_data  in  64  channel samples: [15:0] I0, [31:16] Q0, [47:32] I1, [63:48] Q1.
- adc_enable  in  4  per-channel enable; bit n maps to channel n.
- adc_sync_arm  in  1  one-cycle arm pulse.
- adc_sync  in  1  capture trigger.
- adc_dovf  in  1  DMA overflow indication.
- adc_ovf_clr  in  1  clears the sticky overflow flag.
- adc_ramp_en  in  1  selects the test ramp; functional only with the macro in REQ-016.
- pack_valid  out  1  packed word strobe.
- pack_data  out  64  packed word.
- pack_sync  out  1  marks the first word of a capture.
- adc_ovf_sticky  out  1  sticky overflow flag.

Function
REQ-003 SHALL implement states IDLE, ARMED, RUN:
- IDLE->ARMED on adc_sync_arm when SYNC_ENABLE=1 and adc_enable!=0.
- IDLE->RUN when SYNC_ENABLE=0 and adc_enable!=0.
- ARMED->RUN on a cycle with adc_valid=1 and adc_sync=1; that sample is the first one captured.
REQ-004 SHALL return to IDLE and discard all partial data whenever adc_enable changes value or equals 0, from any state; this takes priority over every other transition.
REQ-005 SHALL, in RUN on each adc_valid cycle, compact the N enabled channel samples (N=1..4) in ascending channel order, with the lowest enabled channel in the lowest bits.
REQ-006 SHALL append compacted samples above the existing residue in an accumulator of at least 112 bits; fill level is tracked in 16-bit units, range 0..7.
REQ-007 SHALL, when fill+N>=4, register the lowest 64 accumulated bits onto pack_data with pack_valid=1 the next cycle and shift the residue (fill+N-4 units) down to bit 0.
REQ-008 SHALL hold pack_valid high for exactly one cycle per word; pack_data is don't-care when pack_valid=0.
REQ-009 SHALL have a latency of 1 cycle, from the adc_valid cycle that completes a word to pack_valid.
REQ-010 SHALL assert pack_sync together with the first pack_valid after each entry into RUN, and never otherwise.
REQ-011 SHALL ignore adc_valid cycles outside RUN (except the triggering sample in REQ-003); adc_sync_arm received in ARMED or RUN has no effect.
REQ-012 SHALL set adc_ovf_sticky when adc_dovf=1 while pack_valid=1, and clear it on adc_ovf_clr; if set and clear coincide, set wins.

Reset
REQ-013 SHALL, on adc_rstn=0 and asynchronously, force state IDLE, fill 0, pack_valid 0, pack_sync 0, pack_data 0, adc_ovf_sticky 0, and ramp counter 0.
REQ-014 SHALL behave after reset deassertion exactly as on a first entry into IDLE; reset asserted mid-word loses the residue without emitting it.
REQ-015 SHALL sample adc_enable into its change-detect register during reset, so the first post-reset cycle is not treated as an enable change.

Configuration
REQ-016 SHALL, with AXI_AD9371_RX_PACK_RAMP_EN defined and adc_ramp_en=1, replace every enabled sample with a 16-bit ramp counter that increments per captured adc_valid, wraps 0xFFFF->0x0000, and clears on entry into RUN.
REQ-017 SHALL, without AXI_AD9371_RX_PACK_RAMP_EN, contain no ramp counter and ignore adc_ramp_en.

Structure
REQ-018 SHALL place the state encoding, the lane width (16), the channel count (4) and the accumulator width (128) in the shared package axi_ad9371_rx_pkg.
REQ-019 SHALL implement the combinational compaction of REQ-005 in the sub-module axi_ad9371_rx_pack_compact; the outputs are N (3 bits) and a 64-bit compacted vector.

Verification
REQ-020 SHALL cover all five scenarios below:
- SYNC_ENABLE=0, enable=0xF, data 0x0004_0003_0002_0001 on every valid -> one word per valid, equal to the input; first word has pack_sync=1.
- enable=0x1, I0 samples 0x0001..0x0008 -> two words, 0x0004_0003_0002_0001 and 0x0008_0007_0006_0005.
- enable=0x7 (N=3), four valids of {I1,Q0,I0}={3k+3,3k+2,3k+1} for k=0..3 -> three words 0x0004..0x0001, 0x0008..0x0005, 0x000C..0x0009.
- SYNC_ENABLE=1: arm, then 10 valids without sync -> no output; sync on valid 11 -> the first word starts with sample 11 and has pack_sync=1.
- Enable 0x1->0x3 after 2 samples -> residue discarded, IDLE, no pack_valid; adc_dovf plus pack_valid together with adc_ovf_clr -> adc_ovf_sticky=1.
